// File: rtl/watch_pkg.sv
// Shared UI state encoding for the watch: mode controller, blink stage and
// time/alarm counters all import these constants.
package watch_pkg;

  typedef enum logic [2:0] {
    ST_NORMAL   = 3'd0,
    ST_SET_HR   = 3'd1,
    ST_SET_MIN  = 3'd2,
    ST_SET_SEC  = 3'd3,
    ST_ALM_VIEW = 3'd4,
    ST_ALM_MIN  = 3'd5,
    ST_ALM_HR   = 3'd6
  } state_t;

  // MODE button walks the ring; anything outside it lands on NORMAL.
  function automatic state_t next_mode(input state_t s);
    case (s)
      ST_NORMAL:   next_mode = ST_SET_HR;
      ST_SET_HR:   next_mode = ST_SET_MIN;
      ST_SET_MIN:  next_mode = ST_SET_SEC;
      ST_SET_SEC:  next_mode = ST_ALM_VIEW;
      ST_ALM_VIEW: next_mode = ST_ALM_MIN;
      ST_ALM_MIN:  next_mode = ST_ALM_HR;
      ST_ALM_HR:   next_mode = ST_NORMAL;
      default:     next_mode = ST_NORMAL;
    endcase
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioner: 2-FF synchronizer, stability-count debouncer and
// a one-cycle pulse on each accepted press (releases are silent).
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic level,
  output logic press
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_r;
  logic          sync2_r;
  logic          level_r;
  logic          press_r;
  logic [CW-1:0] cnt_r;

  // Synchronize, then flip the level only after an unbroken run of differing samples.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
      level_r <= 1'b0;
      press_r <= 1'b0;
      cnt_r   <= {CW{1'b0}};
    end else begin
      sync1_r <= btn_raw;
      sync2_r <= sync1_r;
      press_r <= 1'b0;
      if (sync2_r == level_r) begin
        cnt_r <= {CW{1'b0}};
      end else if (cnt_r == CNT_LAST) begin
        level_r <= sync2_r;
        press_r <= sync2_r;
        cnt_r   <= {CW{1'b0}};
      end else begin
        cnt_r <= cnt_r + CW'(1);
      end
    end
  end

  assign level = level_r;
  assign press = press_r;

endmodule

// File: rtl/watch_mode_ctrl.sv
// Watch UI controller: debounced MODE/SET buttons drive the display/edit mode,
// one-cycle edit pulses, the alarm enable and an inactivity timeout.
module watch_mode_ctrl
  import watch_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 20,
  parameter int TIMEOUT_SEC     = 30
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_mode,
  input  logic       btn_set,
  input  logic       sec_tick,
  output logic [2:0] state,
  output logic       inc_hr,
  output logic       inc_min,
  output logic       zero_sec,
  output logic       alm_inc_hr,
  output logic       alm_inc_min,
  output logic       alm_en
);

  localparam int TW = $clog2(TIMEOUT_SEC + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_SEC - 1);

  logic          press_mode_s;
  logic          press_set_s;
  logic          mode_level_unused_s;
  logic          set_level_unused_s;
  state_t        state_r;
  logic [TW-1:0] to_cnt_r;
  logic          inc_hr_r;
  logic          inc_min_r;
  logic          zero_sec_r;
  logic          alm_inc_hr_r;
  logic          alm_inc_min_r;
  logic          alm_en_r;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_mode (
    .clk     (clk),
    .rst     (rst),
    .btn_raw (btn_mode),
    .level   (mode_level_unused_s),
    .press   (press_mode_s)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_set (
    .clk     (clk),
    .rst     (rst),
    .btn_raw (btn_set),
    .level   (set_level_unused_s),
    .press   (press_set_s)
  );

  // Mode FSM, SET decode and timeout; MODE has priority, any press restarts the timeout.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r       <= ST_NORMAL;
      to_cnt_r      <= {TW{1'b0}};
      inc_hr_r      <= 1'b0;
      inc_min_r     <= 1'b0;
      zero_sec_r    <= 1'b0;
      alm_inc_hr_r  <= 1'b0;
      alm_inc_min_r <= 1'b0;
      alm_en_r      <= 1'b0;
    end else begin
      inc_hr_r      <= 1'b0;
      inc_min_r     <= 1'b0;
      zero_sec_r    <= 1'b0;
      alm_inc_hr_r  <= 1'b0;
      alm_inc_min_r <= 1'b0;
      if (state_r > ST_ALM_HR) begin
        state_r  <= ST_NORMAL;
        to_cnt_r <= {TW{1'b0}};
      end else if (press_mode_s) begin
        state_r  <= next_mode(state_r);
        to_cnt_r <= {TW{1'b0}};
      end else if (press_set_s) begin
        to_cnt_r <= {TW{1'b0}};
        case (state_r)
          ST_NORMAL:   state_r       <= ST_NORMAL;
          ST_SET_HR:   inc_hr_r      <= 1'b1;
          ST_SET_MIN:  inc_min_r     <= 1'b1;
          ST_SET_SEC:  zero_sec_r    <= 1'b1;
          ST_ALM_VIEW: alm_en_r      <= ~alm_en_r;
          ST_ALM_MIN:  alm_inc_min_r <= 1'b1;
          ST_ALM_HR:   alm_inc_hr_r  <= 1'b1;
          default:     state_r       <= ST_NORMAL;
        endcase
      end else if (state_r == ST_NORMAL) begin
        to_cnt_r <= {TW{1'b0}};
      end else if (sec_tick) begin
        if (to_cnt_r == TO_LAST) begin
          state_r  <= ST_NORMAL;
          to_cnt_r <= {TW{1'b0}};
        end else begin
          to_cnt_r <= to_cnt_r + TW'(1);
        end
      end else begin
        to_cnt_r <= to_cnt_r;
      end
    end
  end

  assign state       = state_r;
  assign inc_hr      = inc_hr_r;
  assign inc_min     = inc_min_r;
  assign zero_sec    = zero_sec_r;
  assign alm_inc_hr  = alm_inc_hr_r;
  assign alm_inc_min = alm_inc_min_r;
  assign alm_en      = alm_en_r;

endmodule

// File: tb/tb_watch_mode_ctrl.sv
// Bench for watch_mode_ctrl: directed scenarios plus random button/tick traffic,
// every cycle compared against a behavioural model of the UI rules.
module tb_watch_mode_ctrl;

  localparam int D  = 20;
  localparam int TO = 30;
  localparam int HN = 30000;

  logic       clk = 1'b0;
  logic       rst;
  logic       btn_mode;
  logic       btn_set;
  logic       sec_tick;
  logic [2:0] state;
  logic       inc_hr, inc_min, zero_sec, alm_inc_hr, alm_inc_min, alm_en;

  int vectors     = 0;
  int miscompares = 0;

  // behavioural model
  int       m_state;
  int       m_idle;
  bit       m_alm;
  bit [7:0] m_pulse;      // one-hot by the state in which SET was pressed
  bit       m_s1[2];
  bit       m_s2[2];
  bit       m_lvl[2];
  bit       m_press[2];
  bit       hist[2][HN];  // synchronized samples seen by each debouncer
  int       n    = 0;
  int       base = 0;
  int       pcnt[5];      // DUT pulses seen: inc_hr, inc_min, zero_sec, alm_inc_hr, alm_inc_min

  watch_mode_ctrl #(.DEBOUNCE_CYCLES(D), .TIMEOUT_SEC(TO)) dut (
    .clk         (clk),
    .rst         (rst),
    .btn_mode    (btn_mode),
    .btn_set     (btn_set),
    .sec_tick    (sec_tick),
    .state       (state),
    .inc_hr      (inc_hr),
    .inc_min     (inc_min),
    .zero_sec    (zero_sec),
    .alm_inc_hr  (alm_inc_hr),
    .alm_inc_min (alm_inc_min),
    .alm_en      (alm_en)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_state = 0;
    m_idle  = 0;
    m_alm   = 1'b0;
    m_pulse = 8'd0;
    for (int b = 0; b < 2; b++) begin
      m_s1[b] = 1'b0; m_s2[b] = 1'b0; m_lvl[b] = 1'b0; m_press[b] = 1'b0;
    end
    base = n;
  endtask

  // What the outputs must be after the coming rising edge, given current inputs.
  task automatic model_edge();
    if (rst) begin
      model_reset();
      return;
    end
    m_pulse = 8'd0;
    if (m_press[0]) begin
      m_state = (m_state + 1) % 7;
      m_idle  = 0;
    end else if (m_press[1]) begin
      m_idle = 0;
      if (m_state == 4) m_alm = !m_alm;
      else if (m_state != 0) m_pulse[m_state] = 1'b1;
    end else if (m_state != 0 && sec_tick) begin
      m_idle++;
      if (m_idle >= TO) begin
        m_state = 0;
        m_idle  = 0;
      end
    end
    for (int b = 0; b < 2; b++) begin
      bit ok;
      m_press[b] = 1'b0;
      hist[b][n] = m_s2[b];
      ok = (n - base + 1 >= D);
      for (int k = 0; k < D && ok; k++)
        if (hist[b][n-k] == m_lvl[b]) ok = 1'b0;
      if (ok) begin
        m_lvl[b]   = !m_lvl[b];
        m_press[b] = m_lvl[b];
      end
      m_s2[b] = m_s1[b];
      m_s1[b] = (b == 0) ? btn_mode : btn_set;
    end
    n++;
  endtask

  task automatic compare();
    logic [8:0] act, exp;
    act = {state, inc_hr, inc_min, zero_sec, alm_inc_hr, alm_inc_min, alm_en};
    exp = {3'(m_state), m_pulse[1], m_pulse[2], m_pulse[3], m_pulse[6], m_pulse[5], m_alm};
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL cycle_check t=%0t actual={state,hr,min,sec,ahr,amin,en}=%b required=%b",
               $time, act, exp);
    end
    pcnt[0] += int'(inc_hr);
    pcnt[1] += int'(inc_min);
    pcnt[2] += int'(zero_sec);
    pcnt[3] += int'(alm_inc_hr);
    pcnt[4] += int'(alm_inc_min);
  endtask

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic step();
    model_edge();
    @(negedge clk);
    compare();
  endtask

  task automatic steps(input int cnt);
    repeat (cnt) step();
  endtask

  task automatic press(input bit m, input bit s);
    btn_mode = m; btn_set = s;
    steps(25);
    btn_mode = 1'b0; btn_set = 1'b0;
    steps(25);
  endtask

  task automatic tick();
    sec_tick = 1'b1; step();
    sec_tick = 1'b0; step(); step();
  endtask

  task automatic random_phase(input int cycles, input int toggle_div);
    for (int c = 0; c < cycles; c++) begin
      if ($urandom_range(0, toggle_div - 1) == 0) btn_mode = ~btn_mode;
      if ($urandom_range(0, toggle_div - 1) == 0) btn_set = ~btn_set;
      if ($urandom_range(0, 60) == 0) begin
        btn_mode = 1'b1; btn_set = 1'b1;
      end
      sec_tick = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 1499) == 0) begin
        rst = 1'b1; model_reset();
        #1 compare();
        steps(3);
        rst = 1'b0;
      end
      step();
    end
    btn_mode = 1'b0; btn_set = 1'b0; sec_tick = 1'b0;
    steps(30);
  endtask

  initial begin
    int b0;
    rst = 1'b1; btn_mode = 1'b0; btn_set = 1'b0; sec_tick = 1'b0;
    for (int i = 0; i < 5; i++) pcnt[i] = 0;
    model_reset();
    @(negedge clk);
    compare();
    steps(3);
    chk("reset_state", int'(state), 0);
    chk("reset_alm_en", int'(alm_en), 0);
    rst = 1'b0;
    steps(2);

    // first MODE press: update lands 22 cycles after the first captured edge
    btn_mode = 1'b1;
    steps(22);
    chk("mode_latency_before", int'(state), 0);
    step();
    chk("mode_latency_at", int'(state), 1);
    steps(2);
    btn_mode = 1'b0;
    steps(25);
    for (int i = 2; i <= 7; i++) begin
      press(1'b1, 1'b0);
      chk("mode_sequence", int'(state), i % 7);
    end

    // short glitch is rejected, a long pulse is accepted
    btn_mode = 1'b1; steps(10);
    btn_mode = 1'b0; steps(30);
    chk("glitch_rejected", int'(state), 0);
    press(1'b1, 1'b0);
    chk("long_pulse", int'(state), 1);

    b0 = pcnt[0];
    repeat (3) press(1'b0, 1'b1);
    chk("inc_hr_pulses", pcnt[0] - b0, 3);
    chk("set_keeps_state", int'(state), 1);

    press(1'b1, 1'b0);
    b0 = pcnt[1];
    press(1'b1, 1'b1);
    chk("mode_set_same_state", int'(state), 3);
    chk("mode_set_same_no_inc_min", pcnt[1] - b0, 0);

    b0 = pcnt[2];
    press(1'b0, 1'b1);
    chk("zero_sec_pulse", pcnt[2] - b0, 1);

    press(1'b1, 1'b0);
    press(1'b0, 1'b1);
    chk("alm_en_on", int'(alm_en), 1);
    press(1'b0, 1'b1);
    chk("alm_en_off", int'(alm_en), 0);

    // timeout from ALM_MIN
    press(1'b1, 1'b0);
    repeat (29) tick();
    chk("timeout_29", int'(state), 5);
    sec_tick = 1'b1; step(); sec_tick = 1'b0;
    chk("timeout_30", int'(state), 0);
    step();

    // a press restarts the timeout count
    repeat (5) press(1'b1, 1'b0);
    repeat (10) tick();
    press(1'b0, 1'b1);
    repeat (29) tick();
    chk("timeout_restart_29", int'(state), 5);
    sec_tick = 1'b1; step(); sec_tick = 1'b0;
    chk("timeout_restart_30", int'(state), 0);
    step();

    // reset in ALM_HR with alarm enabled and SET held
    repeat (4) press(1'b1, 1'b0);
    press(1'b0, 1'b1);
    repeat (2) press(1'b1, 1'b0);
    chk("pre_reset_state", int'(state), 6);
    chk("pre_reset_alm_en", int'(alm_en), 1);
    btn_set = 1'b1;
    steps(25);
    rst = 1'b1; model_reset();
    #1;
    compare();
    chk("async_reset_state", int'(state), 0);
    chk("async_reset_alm_en", int'(alm_en), 0);
    steps(3);
    rst = 1'b0;
    b0 = pcnt[0] + pcnt[1] + pcnt[2] + pcnt[3] + pcnt[4];
    steps(30);
    chk("held_set_after_reset_state", int'(state), 0);
    chk("held_set_after_reset_pulses", pcnt[0] + pcnt[1] + pcnt[2] + pcnt[3] + pcnt[4] - b0, 0);
    btn_set = 1'b0;
    steps(25);

    random_phase(4000, 30);
    random_phase(5000, 300);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
